// File: rtl/riscv_cpu_pkg.sv
// Shared types for the memory stage: access sizes, the EX->MEM and MEM->WB
// pipeline records, and the memory-stage FSM states.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] wdata_mux;
    logic [4:0] dest_reg;
    logic       mem_re;
    logic       mem_we;
    mem_size_e  mem_size;
    logic       mem_unsigned;
  } id_stage_t;

  typedef struct packed {
    id_stage_t             id_stage;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
  } ex2mem_t;

  typedef struct packed {
    ex2mem_t               ex_stage;
    logic [DATA_WIDTH-1:0] mem_data;
  } mem2wb_t;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } mem_state_e;

  // Force address low bits to the natural alignment of the access size.
  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input mem_size_e size);
    logic [ADDR_WIDTH-1:0] a;
    a = addr;
    case (size)
      MEM_HALF: a[0]   = 1'b0;
      MEM_WORD: a[1:0] = 2'b00;
      default:  a      = addr;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import riscv_cpu_pkg::*;
(
  input  mem_size_e              size,
  input  logic                   is_unsigned,
  input  logic [1:0]             off,
  input  logic [DATA_WIDTH-1:0]  store_data,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic [3:0]             be,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  load_data
);

  logic [DATA_WIDTH-1:0] shifted;

  // Byte enables, store replication and load extension keyed on access size.
  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    be        = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        be        = 4'b0011 << off;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB. Issues loads/stores over a
// req/gnt/rvalid port, stalls EX while a transaction is outstanding and hands
// a registered result to WB.
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned HALF/WORD accesses into a
// no-request trap (misalign_o pulse, reg_we suppressed); otherwise addresses
// are forced to size alignment.
module mem_stage
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ex2mem_t               mem_pipeline_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output mem2wb_t               wb_pipeline_o,
  output logic                  wb_valid_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  misalign_o
);

  mem_state_e state, state_n;
  ex2mem_t    cap, cur;
  mem2wb_t    wb_q;
  logic       wb_valid_q, misalign_q;

  logic                  is_mem, is_store, mis;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  capture, done, load_done, trap;

  // Outside IDLE the captured copy drives the port so req stays stable.
  assign cur      = (state == IDLE) ? mem_pipeline_i : cap;
  assign is_mem   = cur.id_stage.mem_re | cur.id_stage.mem_we;
  assign is_store = cur.id_stage.mem_we;

`ifdef MEM_MISALIGN_TRAP_EN
  assign addr = cur.alu_result[ADDR_WIDTH-1:0];
  assign mis  = ((cur.id_stage.mem_size == MEM_HALF) && addr[0]) ||
                ((cur.id_stage.mem_size == MEM_WORD) && (addr[1:0] != 2'b00));
`else
  assign addr = align_addr(cur.alu_result[ADDR_WIDTH-1:0], cur.id_stage.mem_size);
  assign mis  = 1'b0;
`endif

  lsu_align u_align (
    .size        (cur.id_stage.mem_size),
    .is_unsigned (cur.id_stage.mem_unsigned),
    .off         (addr[1:0]),
    .store_data  (cur.store_data),
    .rdata       (data_rdata_i),
    .be          (data_be_o),
    .wdata       (data_wdata_o),
    .load_data   (load_data)
  );

  assign data_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o   = is_store;

  // Next-state and handshake decode.
  always_comb begin
    state_n    = state;
    data_req_o = 1'b0;
    ready_o    = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    load_done  = 1'b0;
    trap       = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (!is_mem) begin
            done = 1'b1;
          end else if (mis) begin
            done = 1'b1;
            trap = 1'b1;
          end else begin
            data_req_o = 1'b1;
            if (data_gnt_i) begin
              if (is_store) begin
                done = 1'b1;
              end else begin
                capture = 1'b1;
                state_n = WAIT_RVALID;
              end
            end else begin
              ready_o = 1'b0;
              capture = 1'b1;
              state_n = WAIT_GNT;
            end
          end
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          if (is_store) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_RVALID;
          end
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          done      = 1'b1;
          load_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, captured instruction and registered WB result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cap        <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_n;
      wb_valid_q <= done;
      misalign_q <= trap;
      if (capture) cap <= mem_pipeline_i;
      if (done) begin
        wb_q.ex_stage <= cur;
        wb_q.mem_data <= load_done ? load_data : '0;
        if (trap) wb_q.ex_stage.id_stage.reg_we <= 1'b0;
      end
    end
  end

  assign wb_pipeline_o = wb_q;
  assign wb_valid_o    = wb_valid_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage plus a reset-mid-load sequence.
module tb_mem_stage;
  import riscv_cpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  ex2mem_t               pipe;
  logic                  valid, ready, wb_valid, req, gnt, we, rvalid, misalign;
  mem2wb_t               wb;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata, rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i(clk), .rst_i(rst), .mem_pipeline_i(pipe), .valid_i(valid), .ready_o(ready),
    .wb_pipeline_o(wb), .wb_valid_o(wb_valid), .data_req_o(req), .data_gnt_i(gnt),
    .data_addr_o(addr), .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata), .misalign_o(misalign)
  );

  typedef struct {
    string       name;
    ex2mem_t     in;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    logic        reg_we;
    logic        trap;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ex2mem_t mk(input logic reg_we, input logic re, input logic wr,
                                 input mem_size_e sz, input logic uns,
                                 input logic [31:0] alu, input logic [31:0] sd);
    ex2mem_t e;
    e = '0;
    e.id_stage.reg_we       = reg_we;
    e.id_stage.dest_reg     = 5'd7;
    e.id_stage.mem_re       = re;
    e.id_stage.mem_we       = wr;
    e.id_stage.mem_size     = sz;
    e.id_stage.mem_unsigned = uns;
    e.alu_result            = alu;
    e.store_data            = sd;
    return e;
  endfunction

  task automatic run(input vec_t v);
    bit mem, ld;
    mem = v.in.id_stage.mem_re | v.in.id_stage.mem_we;
    ld  = v.in.id_stage.mem_re & ~v.in.id_stage.mem_we;
    @(negedge clk);
    pipe = v.in; valid = 1'b1; rvalid = 1'b0;
    gnt  = mem && !v.trap && (v.gnt_dly == 0);
    #1;
    if (mem && !v.trap) begin
      chk({v.name, " req"},   32'(req), 32'd1);
      chk({v.name, " addr"},  addr, v.addr);
      chk({v.name, " be"},    32'(be), 32'(v.be));
      chk({v.name, " we"},    32'(we), 32'(!ld));
      if (!ld) chk({v.name, " wdata"}, wdata, v.wdata);
      chk({v.name, " ready"}, 32'(ready), 32'(v.gnt_dly == 0));
    end else begin
      chk({v.name, " req"},   32'(req), 32'd0);
      chk({v.name, " ready"}, 32'(ready), 32'd1);
    end
    for (int k = 1; k <= v.gnt_dly; k++) begin
      @(negedge clk);
      gnt = (k == v.gnt_dly);
      #1;
      chk({v.name, " wait req"},   32'(req), 32'd1);
      chk({v.name, " wait addr"},  addr, v.addr);
      chk({v.name, " wait be"},    32'(be), 32'(v.be));
      chk({v.name, " wait ready"}, 32'(ready), 32'd0);
    end
    if (ld && !v.trap) begin
      for (int k = 1; k <= v.rv_dly; k++) begin
        @(negedge clk);
        valid = 1'b0; gnt = 1'b0;
        rvalid = (k == v.rv_dly);
        rdata  = (k == v.rv_dly) ? v.rdata : 32'h0;
        #1;
        chk({v.name, " rv req"},   32'(req), 32'd0);
        chk({v.name, " rv ready"}, 32'(ready), 32'd0);
        chk({v.name, " rv wbv"},   32'(wb_valid), 32'd0);
      end
    end
    @(negedge clk);
    valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    #1;
    chk({v.name, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({v.name, " mem_data"}, wb.mem_data, v.mem_data);
    chk({v.name, " reg_we"},   32'(wb.ex_stage.id_stage.reg_we), 32'(v.reg_we));
    chk({v.name, " alu"},      wb.ex_stage.alu_result, v.in.alu_result);
    chk({v.name, " misalign"}, 32'(misalign), 32'(v.trap));
    @(negedge clk);
    #1;
    chk({v.name, " wb_valid drop"}, 32'(wb_valid), 32'd0);
    chk({v.name, " misalign drop"}, 32'(misalign), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"ADD",  mk(1,0,0,MEM_WORD,0,32'h1234,0),           0,0,0,            0,        0,       0,            32'h0,        1,0};
    vecs[1] = '{"SB",   mk(0,0,1,MEM_BYTE,0,32'h103,32'hAB),       0,0,0,            32'h100,  4'b1000, 32'hABABABAB, 32'h0,        0,0};
    vecs[2] = '{"SH",   mk(0,0,1,MEM_HALF,0,32'h102,32'h1234CDEF), 1,0,0,            32'h100,  4'b1100, 32'hCDEFCDEF, 32'h0,        0,0};
    vecs[3] = '{"SW",   mk(0,0,1,MEM_WORD,0,32'h104,32'h11223344), 0,0,0,            32'h104,  4'b1111, 32'h11223344, 32'h0,        0,0};
    vecs[4] = '{"LB",   mk(1,1,0,MEM_BYTE,0,32'h102,0),            3,2,32'h00800000, 32'h100,  4'b0100, 0,            32'hFFFFFF80, 1,0};
    vecs[5] = '{"LBU",  mk(1,1,0,MEM_BYTE,1,32'h102,0),            3,2,32'h00800000, 32'h100,  4'b0100, 0,            32'h00000080, 1,0};
    vecs[6] = '{"LH",   mk(1,1,0,MEM_HALF,0,32'h102,0),            0,1,32'h80010000, 32'h100,  4'b1100, 0,            32'hFFFF8001, 1,0};
    vecs[7] = '{"LW",   mk(1,1,0,MEM_WORD,0,32'h100,0),            0,1,32'hDEADBEEF, 32'h100,  4'b1111, 0,            32'hDEADBEEF, 1,0};
    vecs[8] = '{"LHU",  mk(1,1,0,MEM_HALF,1,32'h200,0),            2,3,32'h1234F00F, 32'h200,  4'b0011, 0,            32'h0000F00F, 1,0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[9] = '{"LWMA", mk(1,1,0,MEM_WORD,0,32'h102,0),            0,1,32'hCAFEF00D, 32'h100,  4'b1111, 0,            32'h0,        0,1};
`else
    vecs[9] = '{"LWMA", mk(1,1,0,MEM_WORD,0,32'h102,0),            0,1,32'hCAFEF00D, 32'h100,  4'b1111, 0,            32'hCAFEF00D, 1,0};
`endif

    rst = 1'b1; valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; pipe = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_pipe",  wb.mem_data | wb.ex_stage.alu_result | wb.ex_stage.store_data, 32'd0);
    chk("rst req",      32'(req), 32'd0);
    chk("rst misalign", 32'(misalign), 32'd0);
    chk("rst ready",    32'(ready), 32'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    @(negedge clk);
    pipe = mk(1,1,0,MEM_WORD,0,32'h300,0); valid = 1'b1; gnt = 1'b1;
    @(negedge clk);
    valid = 1'b0; gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h55AA55AA;
    #1;
    chk("rstmid req",      32'(req), 32'd0);
    chk("rstmid wb_valid", 32'(wb_valid), 32'd0);
    chk("rstmid ready",    32'(ready), 32'd1);
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("stray rvalid wb_valid", 32'(wb_valid), 32'd0);
    run(vecs[0]);
    run(vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
